// File: rtl/apb_slave_regbank.sv
// APB slave target with a word-addressed register bank, wait states and error reporting.
// Define APB_WSTRB_EN to add the strb port and per-byte write enables.
module apb_slave_regbank #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 0,
  parameter int WAIT_CYCLES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    other_error,
`ifdef APB_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] strb,
`endif
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slave_error
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   BASE_EXT   = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RO_START   = ADDR_WIDTH'(DEPTH - RO_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    oerr_q, oerr_d;
  logic                    ready_q, ready_d;
  logic                    slverr_q, slverr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic                    in_wait;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    cur_write;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic                    cur_oerr;
  logic [NB-1:0]           cur_strb;
  logic [ADDR_WIDTH:0]     diff;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   index;
  logic [IDX_W-1:0]        idx;
  logic                    err;
  logic [DATA_WIDTH-1:0]   wmerge;
  logic                    complete;

`ifdef APB_WSTRB_EN
  logic [NB-1:0]           strb_q, strb_d;
`endif

  // With zero wait states the transfer completes on the setup edge, so the
  // live bus is decoded; otherwise the values captured at setup are used.
  always_comb begin
    in_wait   = (state_q == S_WAIT);
    cur_addr  = in_wait ? addr_q  : addr;
    cur_write = in_wait ? write_q : write;
    cur_wdata = in_wait ? wdata_q : wdata;
    cur_oerr  = in_wait ? oerr_q  : other_error;
`ifdef APB_WSTRB_EN
    cur_strb  = in_wait ? strb_q  : strb;
`else
    cur_strb  = '1;
`endif
    diff   = {1'b0, cur_addr} - BASE_EXT;
    offset = diff[ADDR_WIDTH-1:0];
    index  = offset >> LSB;
    idx    = index[IDX_W-1:0];
    err    = diff[ADDR_WIDTH]
           | (index >= DEPTH_A)
           | (|(offset & ALIGN_MASK))
           | (cur_write & (index >= RO_START))
           | cur_oerr;
    wmerge = mem_q[idx];
    for (int i = 0; i < NB; i++) begin
      if (cur_strb[i]) wmerge[8*i +: 8] = cur_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    oerr_d   = oerr_q;
`ifdef APB_WSTRB_EN
    strb_d   = strb_q;
`endif
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = rdata_q;
    mem_d    = mem_q;
    complete = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (sel && !enable) begin
          addr_d  = addr;
          write_d = write;
          wdata_d = wdata;
          oerr_d  = other_error;
`ifdef APB_WSTRB_EN
          strb_d  = strb;
`endif
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) complete = 1'b1;
          else                  state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!sel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (enable) begin
          if (cnt_q <= 4'd1) complete = 1'b1;
          else               cnt_d    = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      state_d  = S_DONE;
      cnt_d    = '0;
      ready_d  = 1'b1;
      slverr_d = err;
      rdata_d  = (err || cur_write) ? '0 : mem_q[idx];
      if (!err && cur_write) mem_d[idx] = wmerge;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      oerr_q   <= 1'b0;
`ifdef APB_WSTRB_EN
      strb_q   <= '0;
`endif
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      oerr_q   <= oerr_d;
`ifdef APB_WSTRB_EN
      strb_q   <= strb_d;
`endif
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata       = rdata_q;
  assign ready       = ready_q;
  assign slave_error = slverr_q;

endmodule
